div_tc_32_16: RTL and testbench

DIV_TC_32_16 -- requirements
Module: div_tc_32_16

---
 rtl/div_tc_32_16.sv | 131 +++++++++++++
 tb/tb_div_tc_32_16.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_tc_32_16.sv
// 32/16 two's-complement divider: restoring, one quotient bit per cycle, with valid/ready in and out.
// Build option: DIV_TC_SAT_EN makes the quotient saturate on overflow instead of wrapping.
module div_tc_32_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        ovf,
  output logic        dz,
  output logic [2:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and outputs hold until out_ready.
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_lat;
  logic [15:0] b_lat;
  logic        sign_a, sign_b;
  logic [31:0] q_mag;
  logic [15:0] d_mag;
  logic [16:0] p_rem;
  logic [4:0]  cnt;

  logic [16:0] trial, diff;
  logic        ge;
  logic        neg;
  logic        ovf_c;
  logic [15:0] q_lo, q_fix, rem_c;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PREP;
      PREP:    state_d = (b_lat == 16'd0) ? FIX : CALC;
      CALC:    if (cnt == 5'd31) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  always_comb begin
    trial = {p_rem[15:0], q_mag[31]};
    diff  = trial - {1'b0, d_mag};
    ge    = (trial >= {1'b0, d_mag});
  end

  // Sign application; the magnitude quotient can reach 2^31, so overflow is judged on the full width.
  always_comb begin
    neg   = sign_a ^ sign_b;
    q_lo  = neg ? (16'd0 - q_mag[15:0]) : q_mag[15:0];
    ovf_c = neg ? (q_mag > 32'd32768) : (q_mag > 32'd32767);
    rem_c = sign_a ? (16'd0 - p_rem[15:0]) : p_rem[15:0];
    q_fix = q_lo;
`ifdef DIV_TC_SAT_EN
    if (ovf_c) q_fix = neg ? 16'h8000 : 16'h7FFF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat     <= '0;
      b_lat     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      q_mag     <= '0;
      d_mag     <= '0;
      p_rem     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_lat <= dividend;
            b_lat <= divisor;
          end
        end
        PREP: begin
          sign_a <= a_lat[31];
          sign_b <= b_lat[15];
          q_mag  <= a_lat[31] ? (32'd0 - a_lat) : a_lat;
          d_mag  <= b_lat[15] ? (16'd0 - b_lat) : b_lat;
          p_rem  <= '0;
          cnt    <= '0;
        end
        CALC: begin
          p_rem <= ge ? diff : trial;
          q_mag <= {q_mag[30:0], ge};
          cnt   <= cnt + 5'd1;
        end
        FIX: begin
          if (b_lat == 16'd0) begin
            dz        <= 1'b1;
            ovf       <= 1'b0;
            quotient  <= 16'hFFFF;
            remainder <= a_lat[15:0];
          end else begin
            dz        <= 1'b0;
            ovf       <= ovf_c;
            quotient  <= q_fix;
            remainder <= rem_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_tc_32_16.sv
// Self-checking bench for div_tc_32_16: directed vectors, backpressure, mid-operation reset, random ops.
// Expected results go into a queue at issue time and are compared when out_valid appears.
module tb_div_tc_32_16;

`ifdef DIV_TC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, ovf, dz;
  logic [31:0] dividend;
  logic [15:0] divisor, quotient, remainder;
  logic [2:0]  dbg_state;

  logic [33:0] exp_q[$];  // {dz, ovf, quotient, remainder}
  int n_checks = 0;
  int n_pass   = 0;

  div_tc_32_16 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .ovf(ovf), .dz(dz), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] model(input logic [31:0] a, input logic [15:0] b);
    longint sa, sb, qt, rt;
    logic [15:0] q, r;
    logic o;
    if (b == 16'd0) return {1'b1, 1'b0, 16'hFFFF, a[15:0]};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qt = sa / sb;
    rt = sa % sb;
    o  = (qt > 32767) || (qt < -32768);
    q  = qt[15:0];
    if (o && SAT) q = (qt > 0) ? 16'h7FFF : 16'h8000;
    r  = rt[15:0];
    return {1'b0, o, q, r};
  endfunction

  // Issues one operation and waits for out_valid; lat counts the accept edge as cycle 1.
  task automatic drive_op(input logic [31:0] a, input logic [15:0] b,
                          output logic [33:0] got, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = {dz, ovf, quotient, remainder};
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, quotient, remainder, ovf, dz, dbg_state} !== {1'b1, 1'b0, 32'd0, 2'b00, 3'd0})
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h ovf=%b dz=%b st=%0d want rdy=1 vld=0 rest 0",
               in_ready, out_valid, quotient, remainder, ovf, dz, dbg_state);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [33:0] got, exp;
    int lat;
    exp_q.push_back({1'b0, 1'b0, 16'd142, 16'd6});
    drive_op(32'd1000, 16'd7, got, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL basic_result got %h want %h", got, exp); else n_pass++;
    n_checks++;
    if (lat !== 35) $display("FAIL basic_latency got %0d want 35", lat); else n_pass++;
    release_out();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL basic_ready_after got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_signed();
    logic [33:0] got, exp;
    int lat;
    exp_q.push_back({1'b0, 1'b0, 16'hFF72, 16'hFFFA});
    drive_op(-32'sd1000, 16'd7, got, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL signed_neg_dividend got %h want %h", got, exp); else n_pass++;
    release_out();
    exp_q.push_back({1'b0, 1'b0, 16'hFF72, 16'd6});
    drive_op(32'd1000, -16'sd7, got, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL signed_neg_divisor got %h want %h", got, exp); else n_pass++;
    release_out();
  endtask

  task automatic test_ovf();
    logic [33:0] got, exp;
    int lat;
    exp_q.push_back({1'b0, 1'b1, (SAT ? 16'h7FFF : 16'hFFFF), 16'd0});
    drive_op(32'h7FFFFFFF, 16'd1, got, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL ovf_max_div_1 got %h want %h", got, exp); else n_pass++;
    release_out();
    exp_q.push_back({1'b0, 1'b1, (SAT ? 16'h7FFF : 16'h0000), 16'd0});
    drive_op(32'h80000000, 16'hFFFF, got, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL ovf_min_div_m1 got %h want %h", got, exp); else n_pass++;
    n_checks++;
    if (lat !== 35) $display("FAIL ovf_latency got %0d want 35", lat); else n_pass++;
    release_out();
    // -2^31 / 2^16 is not representable as a divisor, so use -32768 with a large negative dividend
    exp_q.push_back(model(32'h80000000, 16'h8000));
    drive_op(32'h80000000, 16'h8000, got, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL ovf_min_div_min got %h want %h", got, exp); else n_pass++;
    release_out();
  endtask

  task automatic test_dz();
    logic [33:0] got, exp;
    int lat;
    exp_q.push_back({1'b1, 1'b0, 16'hFFFF, 16'h3039});
    drive_op(32'd12345, 16'd0, got, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL dz_result got %h want %h", got, exp); else n_pass++;
    n_checks++;
    if (lat !== 3) $display("FAIL dz_latency got %0d want 3", lat); else n_pass++;
    release_out();
  endtask

  task automatic test_backpressure();
    logic [33:0] got, exp;
    int lat, bad;
    exp_q.push_back(model(-32'sd123456, 16'd100));
    drive_op(-32'sd123456, 16'd100, got, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL bp_result got %h want %h", got, exp); else n_pass++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ({dz, ovf, quotient, remainder} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL bp_hold unstable cycles got %0d want 0", bad); else n_pass++;
    release_out();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
    exp_q.push_back(model(32'd65535, 16'd3));
    drive_op(32'd65535, 16'd3, got, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || lat !== 35) $display("FAIL bp_next_op got %h lat %0d want %h lat 35", got, lat, exp);
    else n_pass++;
    release_out();
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    dividend = 32'd99999;
    divisor  = 16'd13;
    in_valid = 1'b1;
    exp_q.push_back(model(32'd99999, 16'd13));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dbg_state !== 3'd2) $display("FAIL rst_mid_in_calc got state %0d want 2", dbg_state); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, quotient, remainder, ovf, dz, dbg_state} !== {1'b1, 1'b0, 32'd0, 2'b00, 3'd0})
      $display("FAIL rst_mid_async got rdy=%b vld=%b q=%h r=%h st=%0d want rdy=1 vld=0 rest 0",
               in_ready, out_valid, quotient, remainder, dbg_state);
    else n_pass++;
    exp_q.delete();  // the interrupted operation produces no result
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL rst_mid_stale got %0d bad cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_random();
    logic [33:0] got, exp;
    logic [31:0] a;
    logic [15:0] b;
    int lat, bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      a = (i % 3 == 0) ? 32'($urandom_range(0, 200000)) : $urandom;
      case (i % 4)
        0: b = 16'($urandom_range(1, 20));
        1: b = 16'd0 - 16'($urandom_range(1, 300));
        2: b = (i == 6) ? 16'h8000 : 16'($urandom);
        default: b = (i == 11) ? 16'd0 : 16'($urandom);
      endcase
      exp_q.push_back(model(a, b));
      drive_op(a, b, got, lat);
      exp = exp_q.pop_front();
      if (got !== exp || lat !== ((b == 16'd0) ? 3 : 35)) begin
        bad++;
        $display("FAIL random_op a=%h b=%h got %h lat %0d want %h", a, b, got, lat, exp);
      end
      release_out();
    end
    n_checks++;
    if (bad != 0) $display("FAIL random_total got %0d bad ops want 0", bad); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_signed();
    test_ovf();
    test_dz();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
